// File: rtl/branch_control.sv
// branch_control: decodes branch ops, drives PC redirect/flush, keeps Z/N flags and a circular return stack.
// Optional: define BRANCH_FLAG_BYPASS_EN to let BRZ/BRN see same-cycle ZeroIn/NegIn.
module branch_control #(
  parameter int SHADOW   = 2,
  parameter int RS_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_valid_i,
  input  logic [2:0]  branch_op_i,
  input  logic [15:0] instr_addr_i,
  input  logic [8:0]  branch_offset_i,
  input  logic [15:0] target_i,
  input  logic        flags_we_i,
  input  logic        zero_i,
  input  logic        neg_i,
  output logic [15:0] load_value_o,
  output logic        load_enable_o,
  output logic        flush_o,
  output logic        stack_overflow_o,
  output logic        stack_underflow_o
);
  localparam int AW = $clog2(RS_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {S_RUN, S_REDIR, S_SHADOW} state_t;
  state_t         state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [15:0]    lv_q, lv_d;
  logic           z_q, z_d, n_q, n_d;
  logic [AW-1:0]  sp_q, sp_d;
  logic [CW-1:0]  rc_q, rc_d;
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic [15:0]    rs_q [RS_DEPTH];
  logic [15:0]    rs_d [RS_DEPTH];
  logic           acc, zc, nc, empty, full, taken;
  logic           is_br, is_brz, is_brn, is_jmp, is_call, is_ret;
  logic [15:0]    rel, top, tgt;
  assign acc     = instr_valid_i && state_q == S_RUN;
  assign is_br   = branch_op_i == 3'b001;
  assign is_brz  = branch_op_i == 3'b010;
  assign is_brn  = branch_op_i == 3'b011;
  assign is_jmp  = branch_op_i == 3'b100;
  assign is_call = branch_op_i == 3'b101;
  assign is_ret  = branch_op_i == 3'b110;
`ifdef BRANCH_FLAG_BYPASS_EN
  assign zc = flags_we_i ? zero_i : z_q;
  assign nc = flags_we_i ? neg_i : n_q;
`else
  assign zc = z_q;
  assign nc = n_q;
`endif
  assign empty = rc_q == '0;
  assign full  = rc_q == CW'(RS_DEPTH);
  assign rel   = instr_addr_i + {{7{branch_offset_i[8]}}, branch_offset_i};
  assign top   = rs_q[sp_q - AW'(1)];
  assign tgt   = is_ret ? top : (is_jmp || is_call) ? target_i : rel;
  assign taken = acc && (is_br || is_jmp || is_call || (is_brz && zc) || (is_brn && nc) || (is_ret && !empty));
  always_comb begin
    state_d = (state_q == S_RUN) ? (taken ? S_REDIR : S_RUN)
            : (state_q == S_REDIR) ? (SHADOW > 0 ? S_SHADOW : S_RUN)
            : (cnt_q == '0 ? S_RUN : S_SHADOW);
    cnt_d = (state_q == S_REDIR) ? 3'(SHADOW - 1)
          : (state_q == S_SHADOW && cnt_q != '0) ? cnt_q - 3'd1 : cnt_q;
    lv_d  = taken ? tgt : lv_q;
    z_d   = (acc && flags_we_i) ? zero_i : z_q;
    n_d   = (acc && flags_we_i) ? neg_i : n_q;
    sp_d  = sp_q;
    rc_d  = rc_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    rs_d  = rs_q;
    // A push on a full stack lands on the oldest slot, since sp has wrapped onto it
    if (acc && is_call) begin
      rs_d[sp_q] = instr_addr_i + 16'd1;
      sp_d  = sp_q + AW'(1);
      rc_d  = full ? rc_q : rc_q + CW'(1);
      ovf_d = ovf_q | full;
    end
    if (acc && is_ret) begin
      sp_d  = empty ? sp_q : sp_q - AW'(1);
      rc_d  = empty ? rc_q : rc_q - CW'(1);
      unf_d = unf_q | empty;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      lv_q    <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      sp_q    <= '0;
      rc_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lv_q    <= lv_d;
      z_q     <= z_d;
      n_q     <= n_d;
      sp_q    <= sp_d;
      rc_q    <= rc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end
  always_ff @(posedge clk_i) rs_q <= rs_d;
  assign load_value_o      = lv_q;
  assign load_enable_o     = state_q == S_REDIR;
  assign flush_o           = state_q != S_RUN;
  assign stack_overflow_o  = ovf_q;
  assign stack_underflow_o = unf_q;
endmodule

// File: tb/tb_branch_control.sv
// tb_branch_control: directed checks of redirect timing, flags, return stack and async reset.
module tb_branch_control;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, fwe, zin, nin;
  logic [2:0]  op;
  logic [15:0] addr, tgt;
  logic [8:0]  off;
  logic [15:0] lv;
  logic        le, fl, ovf, unf;
  int n_chk = 0;
  int n_fail = 0;

  branch_control #(.SHADOW(2), .RS_DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(valid), .branch_op_i(op),
    .instr_addr_i(addr), .branch_offset_i(off), .target_i(tgt), .flags_we_i(fwe),
    .zero_i(zin), .neg_i(nin), .load_value_o(lv), .load_enable_o(le), .flush_o(fl),
    .stack_overflow_o(ovf), .stack_underflow_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = 1'b0; op = 3'b000; fwe = 1'b0; zin = 1'b0; nin = 1'b0;
    addr = '0; off = '0; tgt = '0;
  endtask

  task automatic instr(input logic [2:0] o, input logic [15:0] a, input logic [8:0] d, input logic [15:0] t);
    valid = 1'b1; op = o; addr = a; off = d; tgt = t; fwe = 1'b0;
  endtask

  task automatic drain();
    idle();
    repeat (3) tick();
  endtask

  logic [15:0] exp_ret [4];

  initial begin
    idle();
    rst_n = 1'b0;
    tick(); tick();
    chk("rst_le", {15'd0, le}, 16'd0);
    chk("rst_flush", {15'd0, fl}, 16'd0);
    chk("rst_lv", lv, 16'h0000);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_le", {15'd0, le}, 16'd0);
    chk("idle_flush", {15'd0, fl}, 16'd0);
    chk("idle_lv", lv, 16'h0000);
    chk("idle_ovf", {15'd0, ovf}, 16'd0);
    chk("idle_unf", {15'd0, unf}, 16'd0);

    instr(3'b001, 16'h0010, 9'h1FC, 16'h0);
    tick();
    chk("br_lv", lv, 16'h000C);
    chk("br_le", {15'd0, le}, 16'd1);
    chk("br_flush0", {15'd0, fl}, 16'd1);
    instr(3'b001, 16'h0050, 9'h008, 16'h0);
    tick();
    chk("br_le_not_twice", {15'd0, le}, 16'd0);
    chk("br_flush1", {15'd0, fl}, 16'd1);
    tick();
    chk("br_flush2", {15'd0, fl}, 16'd1);
    chk("shadow_br_ignored_le", {15'd0, le}, 16'd0);
    tick();
    chk("br_flush_end", {15'd0, fl}, 16'd0);
    chk("shadow_br_ignored_lv", lv, 16'h000C);
    chk("shadow_br_ignored_le2", {15'd0, le}, 16'd0);
    idle();
    tick();

    valid = 1'b1; fwe = 1'b1; zin = 1'b1;
    tick();
    chk("flags_only_le", {15'd0, le}, 16'd0);
    chk("flags_only_flush", {15'd0, fl}, 16'd0);
    instr(3'b010, 16'h0020, 9'h005, 16'h0);
    tick();
    chk("brz_taken_lv", lv, 16'h0025);
    chk("brz_taken_le", {15'd0, le}, 16'd1);
    drain();
    valid = 1'b1; fwe = 1'b1; zin = 1'b0;
    tick();
    instr(3'b010, 16'h0030, 9'h005, 16'h0);
    tick();
    chk("brz_nt_le", {15'd0, le}, 16'd0);
    chk("brz_nt_flush", {15'd0, fl}, 16'd0);
    chk("brz_nt_lv", lv, 16'h0025);
    instr(3'b010, 16'h0030, 9'h007, 16'h0);
    fwe = 1'b1; zin = 1'b1;
    tick();
`ifdef BRANCH_FLAG_BYPASS_EN
    chk("brz_same_cycle_le", {15'd0, le}, 16'd1);
    chk("brz_same_cycle_lv", lv, 16'h0037);
`else
    chk("brz_same_cycle_le", {15'd0, le}, 16'd0);
    chk("brz_same_cycle_lv", lv, 16'h0025);
`endif
    drain();
    valid = 1'b1; fwe = 1'b1; nin = 1'b1;
    tick();
    instr(3'b011, 16'h0002, 9'h1FC, 16'h0);
    tick();
    chk("brn_wrap_lv", lv, 16'hFFFE);
    chk("brn_wrap_le", {15'd0, le}, 16'd1);
    drain();
    instr(3'b111, 16'h0002, 9'h010, 16'h1234);
    tick();
    chk("op7_le", {15'd0, le}, 16'd0);
    chk("op7_lv", lv, 16'hFFFE);
    instr(3'b100, 16'h0009, 9'h0, 16'hABCD);
    tick();
    chk("jmp_lv", lv, 16'hABCD);
    chk("jmp_le", {15'd0, le}, 16'd1);
    drain();

    instr(3'b101, 16'h0040, 9'h0, 16'h0100);
    tick();
    chk("call_lv", lv, 16'h0100);
    chk("call_le", {15'd0, le}, 16'd1);
    drain();
    instr(3'b110, 16'h0105, 9'h0, 16'h0);
    tick();
    chk("ret_lv", lv, 16'h0041);
    chk("ret_le", {15'd0, le}, 16'd1);
    drain();
    chk("unf_before", {15'd0, unf}, 16'd0);
    instr(3'b110, 16'h0042, 9'h0, 16'h0);
    tick();
    chk("ret_empty_le", {15'd0, le}, 16'd0);
    chk("ret_empty_flush", {15'd0, fl}, 16'd0);
    chk("ret_empty_unf", {15'd0, unf}, 16'd1);
    chk("ret_empty_lv", lv, 16'h0041);
    idle();
    tick();

    for (int i = 1; i <= 5; i++) begin
      instr(3'b101, 16'(i), 9'h0, 16'h0200 + 16'(i));
      tick();
      chk("call_n_lv", lv, 16'h0200 + 16'(i));
      chk("call_n_ovf", {15'd0, ovf}, (i == 5) ? 16'd1 : 16'd0);
      drain();
    end
    exp_ret[0] = 16'h0006; exp_ret[1] = 16'h0005; exp_ret[2] = 16'h0004; exp_ret[3] = 16'h0003;
    for (int i = 0; i < 4; i++) begin
      instr(3'b110, 16'h0300, 9'h0, 16'h0);
      tick();
      chk("ret_order_lv", lv, exp_ret[i]);
      chk("ret_order_le", {15'd0, le}, 16'd1);
      drain();
    end
    instr(3'b110, 16'h0300, 9'h0, 16'h0);
    tick();
    chk("ret_after_drain_le", {15'd0, le}, 16'd0);
    chk("ovf_sticky", {15'd0, ovf}, 16'd1);
    idle();
    tick();

    instr(3'b001, 16'h0300, 9'h000, 16'h0);
    tick();
    idle();
    tick();
    chk("pre_reset_flush", {15'd0, fl}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flush", {15'd0, fl}, 16'd0);
    chk("async_rst_le", {15'd0, le}, 16'd0);
    chk("async_rst_lv", lv, 16'h0000);
    chk("async_rst_ovf", {15'd0, ovf}, 16'd0);
    chk("async_rst_unf", {15'd0, unf}, 16'd0);
    tick();
    rst_n = 1'b1;
    tick();
    instr(3'b001, 16'h0000, 9'h001, 16'h0);
    tick();
    chk("post_rst_br_lv", lv, 16'h0001);
    chk("post_rst_br_le", {15'd0, le}, 16'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
